// File: rtl/quire_arbiter_if.sv
// Bundle of requester, quire-forward, quire-return and result signals around the quire arbiter.
// "slave" is the arbiter's view; "master" is the surrounding environment's view.
interface quire_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   req_rts;
  logic [NUM_REQ-1:0]   req_rtr;
  logic [NUM_REQ-1:0]   req_sow;
  logic [NUM_REQ-1:0]   req_eow;
  logic [4*NUM_REQ-1:0] req_frac;
  logic [4*NUM_REQ-1:0] req_scale;
  logic [NUM_REQ-1:0]   req_sign;
  logic [NUM_REQ-1:0]   req_zero;
  logic [NUM_REQ-1:0]   req_nar;

  logic                 q_rts;
  logic                 q_rtr;
  logic                 q_sow;
  logic                 q_eow;
  logic                 q_sign;
  logic                 q_zero;
  logic                 q_nar;
  logic [3:0]           q_frac;
  logic [3:0]           q_scale;

  logic                 qo_rts;
  logic                 qo_eow;
  logic                 qo_rtr;

  logic                 res_rts;
  logic                 res_eow;
  logic                 res_rtr;
  logic [ID_W-1:0]      res_id;

  logic                 err;

  modport slave (
    input  req_rts, req_sow, req_eow, req_frac, req_scale, req_sign, req_zero, req_nar,
    output req_rtr,
    output q_rts, q_sow, q_eow, q_sign, q_zero, q_nar, q_frac, q_scale,
    input  q_rtr,
    input  qo_rts, qo_eow,
    output qo_rtr,
    output res_rts, res_eow, res_id,
    input  res_rtr,
    output err
  );

  modport master (
    output req_rts, req_sow, req_eow, req_frac, req_scale, req_sign, req_zero, req_nar,
    input  req_rtr,
    input  q_rts, q_sow, q_eow, q_sign, q_zero, q_nar, q_frac, q_scale,
    output q_rtr,
    output qo_rts, qo_eow,
    input  qo_rtr,
    input  res_rts, res_eow, res_id,
    output res_rtr,
    input  err
  );
endinterface

// File: rtl/quire_arbiter.sv
// Round-robin, window-locked arbiter sharing one quire between NUM_REQ product streams,
// with an owner-id FIFO that tags each eow result on the return path.
module quire_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ID_DEPTH = 4
) (
  input logic           clk,
  input logic           rst,
  quire_arbiter_if.slave bus
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int PTR_W = $clog2(ID_DEPTH);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]       state;
  logic [ID_W-1:0]  owner;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  pick;
  logic             pick_valid;
  logic             pushed;
  logic [NUM_REQ-1:0] cand;
  logic [NUM_REQ-1:0] drop;
  int               idx;

  logic [ID_W-1:0]  fifo_mem [ID_DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fwd_xfer;
  logic             push;
  logic             pop;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

  assign cand = (state == IDLE) ? (bus.req_rts & bus.req_sow) : '0;
  assign drop = (state == IDLE && !rst) ? (bus.req_rts & ~bus.req_sow) : '0;

  // First sow candidate at or after rr_ptr, searching cyclically.
  always_comb begin
    pick       = '0;
    pick_valid = 1'b0;
    idx        = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_REQ;
      if (!pick_valid && cand[idx]) begin
        pick       = ID_W'(idx);
        pick_valid = 1'b1;
      end
    end
  end

  always_comb begin
    bus.req_rtr = drop;
    bus.q_rts   = 1'b0;
    bus.q_sow   = 1'b0;
    bus.q_eow   = 1'b0;
    bus.q_sign  = 1'b0;
    bus.q_zero  = 1'b0;
    bus.q_nar   = 1'b0;
    bus.q_frac  = '0;
    bus.q_scale = '0;
    if (state == BUSY && !rst) begin
      bus.req_rtr        = '0;
      bus.req_rtr[owner] = bus.q_rtr;
      bus.q_rts          = bus.req_rts[owner];
      bus.q_sow          = bus.req_sow[owner];
      bus.q_eow          = bus.req_eow[owner];
      bus.q_sign         = bus.req_sign[owner];
      bus.q_zero         = bus.req_zero[owner];
      bus.q_nar          = bus.req_nar[owner];
      bus.q_frac         = bus.req_frac[int'(owner)*4 +: 4];
      bus.q_scale        = bus.req_scale[int'(owner)*4 +: 4];
    end
  end

  assign bus.err     = |drop;
  assign bus.qo_rtr  = bus.res_rtr;
  assign bus.res_rts = bus.qo_rts & ~rst;
  assign bus.res_eow = bus.qo_eow & ~rst;
  assign bus.res_id  = (fifo_empty || rst) ? '0 : fifo_mem[rd_ptr[PTR_W-1:0]];

  // Only the first beat of a window records its owner; a mid-window sow does not.
  assign fwd_xfer = bus.q_rts & bus.q_rtr;
  assign push     = fwd_xfer & ~pushed;
  assign pop      = bus.res_rts & bus.res_rtr & bus.qo_eow & ~fifo_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      owner  <= '0;
      rr_ptr <= '0;
      pushed <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid && !fifo_full) begin
            state  <= BUSY;
            owner  <= pick;
            pushed <= 1'b0;
          end
        end
        BUSY: begin
          if (fwd_xfer) begin
            pushed <= 1'b1;
            if (bus.q_eow) begin
              state  <= IDLE;
              rr_ptr <= (owner == ID_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[PTR_W-1:0]] <= owner;
  end
endmodule

// File: tb/tb_quire_arbiter.sv
// Scoreboard bench for quire_arbiter: expected forwarded beats and result ids are queued
// as windows are offered, and a negedge monitor pops and compares on every transfer.
module tb_quire_arbiter;
  localparam int NUM_REQ  = 4;
  localparam int ID_DEPTH = 4;

  typedef struct packed {
    logic       sow;
    logic       eow;
    logic [3:0] frac;
    logic [3:0] scale;
    logic       sign;
    logic       zero;
    logic       nar;
  } beat_t;

  typedef struct {
    beat_t b;
    int    gap;
  } exp_t;

  logic clk;
  logic rst;

  quire_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  quire_arbiter #(.NUM_REQ(NUM_REQ), .ID_DEPTH(ID_DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  beat_t      rq [NUM_REQ][$];
  exp_t       exp_q [$];
  logic [1:0] exp_id [$];

  int  n_checks = 0;
  int  n_pass   = 0;
  int  cyc      = 0;
  int  last_q_cyc = 0;
  int  first_pop_cyc = 0;
  int  q_xfer_cnt = 0;
  int  err_cnt  = 0;
  int  pending  = 0;
  bit  r1_done  = 0;
  bit  stub_en  = 1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic beat_t mk(input int k, input int j, input logic sow, input logic eow);
    beat_t b;
    logic [1:0] kk;
    logic [1:0] jj;
    kk      = k[1:0];
    jj      = j[1:0];
    b.sow   = sow;
    b.eow   = eow;
    b.frac  = {kk, jj};
    b.scale = 4'(k * 5 + j * 3 + 1);
    b.sign  = jj[0];
    b.zero  = (k == 2 && j == 1);
    b.nar   = (k == 3 && eow);
    return b;
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One window of n beats from requester k; expected beats and owner id queued in order.
  task automatic offer(input int k, input int n, input int gap_first, input int gap_rest);
    beat_t b;
    exp_t  e;
    for (int j = 0; j < n; j++) begin
      b = mk(k, j, j == 0, j == n - 1);
      rq[k].push_back(b);
      e.b   = b;
      e.gap = (j == 0) ? gap_first : gap_rest;
      exp_q.push_back(e);
    end
    exp_id.push_back(k[1:0]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int k = 0; k < NUM_REQ; k++) rq[k].delete();
    exp_q.delete();
    exp_id.delete();
    pending = 0;
    r1_done = 0;
    cycles(2);
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    bit done;
    done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      cycles(1);
      done = (exp_q.size() == 0) && (exp_id.size() == 0) && (pending == 0);
      for (int k = 0; k < NUM_REQ; k++) if (rq[k].size() != 0) done = 0;
    end
    check(name, 32'(done), 32'd1);
  endtask

  // Requester drivers plus a quire-return stub that emits one eow result per forwarded window.
  initial begin : env
    logic [NUM_REQ-1:0] xfer;
    logic [NUM_REQ-1:0] rts_v, sow_v, eow_v, sign_v, zero_v, nar_v;
    logic [4*NUM_REQ-1:0] frac_v, scale_v;
    beat_t b;
    bus.req_rts = '0; bus.req_sow = '0; bus.req_eow = '0;
    bus.req_frac = '0; bus.req_scale = '0;
    bus.req_sign = '0; bus.req_zero = '0; bus.req_nar = '0;
    bus.qo_rts = 1'b0; bus.qo_eow = 1'b0;
    forever begin
      @(negedge clk);
      xfer = bus.req_rts & bus.req_rtr;
      @(posedge clk);
      #2;
      rts_v = '0; sow_v = '0; eow_v = '0; sign_v = '0; zero_v = '0; nar_v = '0;
      frac_v = '0; scale_v = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
        if (xfer[k] && rq[k].size() > 0) void'(rq[k].pop_front());
        if (rq[k].size() > 0) begin
          b = rq[k][0];
          rts_v[k] = 1'b1; sow_v[k] = b.sow; eow_v[k] = b.eow;
          sign_v[k] = b.sign; zero_v[k] = b.zero; nar_v[k] = b.nar;
          frac_v[4*k +: 4] = b.frac; scale_v[4*k +: 4] = b.scale;
        end
      end
      bus.req_rts = rts_v; bus.req_sow = sow_v; bus.req_eow = eow_v;
      bus.req_sign = sign_v; bus.req_zero = zero_v; bus.req_nar = nar_v;
      bus.req_frac = frac_v; bus.req_scale = scale_v;
      bus.qo_rts = stub_en && (pending > 0);
      bus.qo_eow = stub_en && (pending > 0);
    end
  end

  initial begin : monitor
    beat_t got;
    exp_t  e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.q_rts && bus.q_rtr) begin
          got = {bus.q_sow, bus.q_eow, bus.q_frac, bus.q_scale, bus.q_sign, bus.q_zero, bus.q_nar};
          q_xfer_cnt++;
          if (exp_q.size() == 0) begin
            check("fwd_unexpected", 32'(exp_q.size()), 32'd1);
          end else begin
            e = exp_q.pop_front();
            check("fwd_beat", 32'(got), 32'(e.b));
            if (e.gap > 0) check("fwd_gap", 32'(cyc - last_q_cyc), 32'(e.gap));
          end
          last_q_cyc = cyc;
          if (got.eow) begin
            pending++;
            if (got.frac[3:2] == 2'd1) r1_done = 1;
          end
        end
        if (bus.res_rts && bus.res_rtr && bus.res_eow) begin
          if (exp_id.size() == 0) check("res_unexpected", 32'(exp_id.size()), 32'd1);
          else check("res_id", 32'(bus.res_id), 32'(exp_id.pop_front()));
          if (pending > 0) pending--;
          if (first_pop_cyc < 0) first_pop_cyc = cyc;
        end
        if (bus.err) err_cnt++;
      end
    end
  end

  task automatic applyStimulus();
    // T1: reset with every requester offering a beat and the quire returning a result.
    rst = 1'b1; bus.q_rtr = 1'b1; bus.res_rtr = 1'b1; pending = 1;
    for (int k = 0; k < NUM_REQ; k++) rq[k].push_back(mk(k, 0, 1'b0, 1'b0));
    cycles(2);
    @(negedge clk);
    check("t1_req_rtr", 32'(bus.req_rtr), 32'd0);
    check("t1_q_rts", 32'(bus.q_rts), 32'd0);
    check("t1_res_rts", 32'(bus.res_rts), 32'd0);
    check("t1_err", 32'(bus.err), 32'd0);
    check("t1_qo_rtr_hi", 32'(bus.qo_rtr), 32'd1);
    bus.res_rtr = 1'b0;
    #1;
    check("t1_qo_rtr_lo", 32'(bus.qo_rtr), 32'd0);
    bus.res_rtr = 1'b1;
    cycles(1);
    do_reset();
    @(negedge clk);
    check("t1_idle_rtr", 32'(bus.req_rtr), 32'd0);
    check("t1_idle_res_id", 32'(bus.res_id), 32'd0);
    cycles(1);

    // T2: req0 and req2 both open 3-beat windows; req0 first, req2 one idle cycle later.
    offer(0, 3, -1, 1);
    offer(2, 3, 2, 1);
    wait_drain("t2_drain", 100);

    // T3: all four stream 1-beat windows; round-robin 0,1,2,3,0 at one window per 2 cycles.
    do_reset();
    offer(0, 1, -1, -1);
    offer(1, 1, 2, -1);
    offer(2, 1, 2, -1);
    offer(3, 1, 2, -1);
    offer(0, 1, 2, -1);
    wait_drain("t3_drain", 100);

    // T4: req1's window under toggling backpressure; req3 must stay locked out.
    do_reset();
    offer(1, 4, -1, -1);
    offer(3, 1, -1, -1);
    for (int i = 0; i < 12; i++) begin
      bus.q_rtr = (i % 2 == 0);
      @(negedge clk);
      if (!r1_done) check("t4_req3_rtr", 32'(bus.req_rtr[3]), 32'd0);
      cycles(1);
    end
    bus.q_rtr = 1'b1;
    wait_drain("t4_drain", 100);

    // T5: results blocked, FIFO fills after four windows; the fifth waits for a pop.
    do_reset();
    bus.res_rtr = 1'b0;
    q_xfer_cnt = 0;
    offer(0, 1, -1, -1);
    offer(1, 1, 2, -1);
    offer(2, 1, 2, -1);
    offer(3, 1, 2, -1);
    offer(0, 1, -1, -1);
    cycles(14);
    @(negedge clk);
    check("t5_fwd_count", 32'(q_xfer_cnt), 32'd4);
    check("t5_req_rtr", 32'(bus.req_rtr), 32'd0);
    check("t5_q_rts", 32'(bus.q_rts), 32'd0);
    cycles(1);
    first_pop_cyc = -1;
    bus.res_rtr = 1'b1;
    wait_drain("t5_drain", 100);
    check("t5_grant_after_pop", 32'(last_q_cyc - first_pop_cyc), 32'd2);

    // T6: a non-sow beat in IDLE is dropped with a 1-cycle err, then reset mid-window.
    do_reset();
    err_cnt = 0;
    q_xfer_cnt = 0;
    rq[2].push_back(mk(2, 0, 1'b0, 1'b0));
    @(negedge clk);
    check("t6_err_hi", 32'(bus.err), 32'd1);
    check("t6_drop_rtr", 32'(bus.req_rtr), 32'h4);
    @(negedge clk);
    check("t6_err_lo", 32'(bus.err), 32'd0);
    cycles(3);
    check("t6_err_count", 32'(err_cnt), 32'd1);
    check("t6_dropped", 32'(rq[2].size()), 32'd0);
    check("t6_no_fwd", 32'(q_xfer_cnt), 32'd0);
    begin
      exp_t e;
      for (int j = 0; j < 3; j++) rq[1].push_back(mk(1, j, j == 0, j == 2));
      e.b = mk(1, 0, 1'b1, 1'b0);
      e.gap = -1;
      exp_q.push_back(e);
    end
    cycles(2);
    check("t6_first_beat", 32'(exp_q.size()), 32'd0);
    do_reset();
    @(negedge clk);
    check("t6_rst_q_rts", 32'(bus.q_rts), 32'd0);
    check("t6_rst_res_id", 32'(bus.res_id), 32'd0);
    cycles(1);
    offer(3, 1, -1, -1);
    wait_drain("t6_drain", 100);
  endtask

  task automatic checkOutput();
    $display("%0d/%0d checks passed", n_pass, n_checks);
  endtask

  initial begin
    rst = 1'b1;
    bus.q_rtr = 1'b0;
    bus.res_rtr = 1'b0;
    applyStimulus();
    checkOutput();
    $finish;
  end
endmodule
